// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - Handshaked parametrised ALU with iterative unsigned multiply/divide.
// Single-cycle ops register on the accept edge; MUL/MULHU/DIVU/REMU take WIDTH radix-2 steps.
module alu_seq #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic [3:0]       ALU_control,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             zero,
   output logic             cout,
   output logic             overflow
);

   localparam int SHW = $clog2(WIDTH);
   localparam logic [SHW-1:0] LAST_STEP = SHW'(WIDTH - 1);

   localparam logic [3:0] OP_AND  = 4'b0000;
   localparam logic [3:0] OP_OR   = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SLTU = 4'b0011;
   localparam logic [3:0] OP_SLL  = 4'b0100;
   localparam logic [3:0] OP_SRL  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0110;
   localparam logic [3:0] OP_SLT  = 4'b0111;
   localparam logic [3:0] OP_NOR  = 4'b1100;
   localparam logic [3:0] OP_SRA  = 4'b1101;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      DONE = 2'b10
   } state_e;

   state_e           state_q, state_d;
   logic             in_ready_q, in_ready_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] opnd_q, opnd_d;
   logic [1:0]       mop_q, mop_d;
   logic [SHW-1:0]   cnt_q, cnt_d;
   logic [WIDTH-1:0] result_q, result_d;
   logic             zero_q, zero_d;
   logic             cout_q, cout_d;
   logic             ovf_q, ovf_d;

   logic [WIDTH:0]   add_w;
   logic [WIDTH:0]   sub_w;
   logic [SHW-1:0]   shamt;
   logic [WIDTH-1:0] alu_res;
   logic             alu_cout;
   logic             alu_ovf;
   logic             is_multi;

   logic [WIDTH:0]   mul_sum;
   logic [WIDTH:0]   div_sh;
   logic             div_ge;
   logic [WIDTH-1:0] div_sub;
   logic [WIDTH-1:0] step_hi;
   logic [WIDTH-1:0] step_lo;
   logic [WIDTH-1:0] fin_res;

   assign add_w    = {1'b0, src1} + {1'b0, src2};
   assign sub_w    = {1'b0, src1} + {1'b0, ~src2} + {{WIDTH{1'b0}}, 1'b1};
   assign shamt    = src2[SHW-1:0];
   assign is_multi = (ALU_control[3:2] == 2'b10);

   always_comb begin
      alu_res  = '0;
      alu_cout = 1'b0;
      alu_ovf  = 1'b0;
      case (ALU_control)
         OP_AND:  alu_res = src1 & src2;
         OP_OR:   alu_res = src1 | src2;
         OP_NOR:  alu_res = ~(src1 | src2);
         OP_ADD: begin
            alu_res  = add_w[WIDTH-1:0];
            alu_cout = add_w[WIDTH];
            alu_ovf  = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_w[WIDTH-1] != src1[WIDTH-1]);
         end
         OP_SUB: begin
            alu_res  = sub_w[WIDTH-1:0];
            alu_cout = sub_w[WIDTH];
            alu_ovf  = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_w[WIDTH-1] != src1[WIDTH-1]);
         end
         OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(src1) < $signed(src2))};
         OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (src1 < src2)};
         OP_SLL:  alu_res = src1 << shamt;
         OP_SRL:  alu_res = src1 >> shamt;
         OP_SRA:  alu_res = $unsigned($signed(src1) >>> shamt);
         default: alu_res = '0;
      endcase
   end

   // hi/lo form one 2*WIDTH register: product {hi,lo} for multiply, {remainder,quotient} for divide.
   assign mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
   assign div_sh  = {hi_q, lo_q[WIDTH-1]};
   assign div_ge  = (div_sh >= {1'b0, opnd_q});
   assign div_sub = div_sh[WIDTH-1:0] - opnd_q;
   assign step_hi = mop_q[1] ? (div_ge ? div_sub : div_sh[WIDTH-1:0]) : mul_sum[WIDTH:1];
   assign step_lo = mop_q[1] ? {lo_q[WIDTH-2:0], div_ge} : {mul_sum[0], lo_q[WIDTH-1:1]};
   assign fin_res = mop_q[0] ? step_hi : step_lo;

   always_comb begin
      state_d  = state_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      opnd_d   = opnd_q;
      mop_d    = mop_q;
      cnt_d    = cnt_q;
      result_d = result_q;
      zero_d   = zero_q;
      cout_d   = cout_q;
      ovf_d    = ovf_q;
      case (state_q)
         IDLE: begin
            if (in_valid && in_ready_q) begin
               if (is_multi) begin
                  hi_d    = '0;
                  lo_d    = src1;
                  opnd_d  = src2;
                  mop_d   = ALU_control[1:0];
                  cnt_d   = '0;
                  state_d = BUSY;
               end else begin
                  result_d = alu_res;
                  zero_d   = (alu_res == '0);
                  cout_d   = alu_cout;
                  ovf_d    = alu_ovf;
                  state_d  = DONE;
               end
            end
         end
         BUSY: begin
            hi_d  = step_hi;
            lo_d  = step_lo;
            cnt_d = cnt_q + SHW'(1);
            if (cnt_q == LAST_STEP) begin
               // A zero divisor naturally yields all-ones quotient and remainder == dividend.
               result_d = fin_res;
               zero_d   = (fin_res == '0);
               cout_d   = 1'b0;
               ovf_d    = mop_q[1] && (opnd_q == '0);
               state_d  = DONE;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      in_ready_d = (state_d == IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         in_ready_q <= 1'b0;
         hi_q       <= '0;
         lo_q       <= '0;
         opnd_q     <= '0;
         mop_q      <= '0;
         cnt_q      <= '0;
         result_q   <= '0;
         zero_q     <= 1'b0;
         cout_q     <= 1'b0;
         ovf_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         in_ready_q <= in_ready_d;
         hi_q       <= hi_d;
         lo_q       <= lo_d;
         opnd_q     <= opnd_d;
         mop_q      <= mop_d;
         cnt_q      <= cnt_d;
         result_q   <= result_d;
         zero_q     <= zero_d;
         cout_q     <= cout_d;
         ovf_q      <= ovf_d;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = (state_q == DONE);
   assign result    = result_q;
   assign zero      = zero_q;
   assign cout      = cout_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb/tb_alu_seq.sv - Self-checking bench for alu_seq (WIDTH=32 and WIDTH=8 instances).
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid, in_ready, out_valid, out_ready;
   logic [31:0] src1, src2, result;
   logic [3:0]  ctrl;
   logic        zero, cout, overflow;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  src1_8, src2_8, result8;
   logic [3:0]  ctrl8;
   logic        zero8, cout8, overflow8;

   int          n_assert = 0;
   int          n_fail   = 0;
   logic [34:0] e;
   int          n;

   always #5 clk = ~clk;

   alu_seq #(.WIDTH(32)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .src1(src1), .src2(src2), .ALU_control(ctrl), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .zero(zero), .cout(cout), .overflow(overflow)
   );

   alu_seq #(.WIDTH(8)) u_dut8 (
      .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
      .src1(src1_8), .src2(src2_8), .ALU_control(ctrl8), .out_valid(out_valid8),
      .out_ready(out_ready8), .result(result8), .zero(zero8), .cout(cout8), .overflow(overflow8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_assert++;
      assert (got === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: {zero, cout, overflow, result} from plain integer arithmetic.
   function automatic logic [34:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] r;
      logic        c, v;
      longint      sa, sb, sr;
      logic [63:0] p;
      r  = '0;
      c  = 1'b0;
      v  = 1'b0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(a) * 64'(b);
      case (op)
         4'b0000: r = a & b;
         4'b0001: r = a | b;
         4'b1100: r = ~(a | b);
         4'b0010: begin
            p  = 64'(a) + 64'(b);
            r  = p[31:0];
            c  = p[32];
            sr = sa + sb;
            v  = (sr != longint'($signed(r)));
         end
         4'b0110: begin
            r  = a - b;
            c  = (a >= b);
            sr = sa - sb;
            v  = (sr != longint'($signed(r)));
         end
         4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
         4'b0011: r = (a < b) ? 32'd1 : 32'd0;
         4'b0100: r = a << b[4:0];
         4'b0101: r = a >> b[4:0];
         4'b1101: r = 32'($signed(a) >>> b[4:0]);
         4'b1000: r = p[31:0];
         4'b1001: r = p[63:32];
         4'b1010: begin
            r = (b == 0) ? 32'hFFFF_FFFF : a / b;
            v = (b == 0);
         end
         4'b1011: begin
            r = (b == 0) ? a : a % b;
            v = (b == 0);
         end
         default: r = '0;
      endcase
      return {(r == 32'd0), c, v, r};
   endfunction

   task automatic do_op(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [34:0] x;
      int          k, lat;
      x   = ref_alu(op, a, b);
      lat = (op[3:2] == 2'b10) ? 32 : 0;
      k   = 0;
      while (!in_ready && k < 100) begin
         tick();
         k++;
      end
      check({tag, "/in_ready"}, in_ready, 1);
      in_valid = 1'b1;
      src1     = a;
      src2     = b;
      ctrl     = op;
      tick();
      k = 0;
      while (!out_valid && k < 200) begin
         src1     = $urandom;
         src2     = $urandom;
         ctrl     = 4'($urandom);
         in_valid = 1'($urandom);
         tick();
         k++;
      end
      in_valid = 1'b0;
      check({tag, "/latency"}, k, lat);
      check({tag, "/result"}, result, x[31:0]);
      check({tag, "/flags"}, {zero, cout, overflow}, x[34:32]);
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check({tag, "/handoff"}, {out_valid, in_ready}, 2'b01);
   endtask

   task automatic do_op8(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
      logic [15:0] p;
      logic [7:0]  r;
      int          k;
      p = 16'(a) * 16'(b);
      case (op)
         4'b1000: r = p[7:0];
         4'b1001: r = p[15:8];
         4'b1010: r = (b == 0) ? 8'hFF : a / b;
         default: r = (b == 0) ? a : a % b;
      endcase
      check({tag, "/in_ready"}, in_ready8, 1);
      in_valid8 = 1'b1;
      src1_8    = a;
      src2_8    = b;
      ctrl8     = op;
      tick();
      in_valid8 = 1'b0;
      k = 0;
      while (!out_valid8 && k < 50) begin
         src1_8 = 8'($urandom);
         src2_8 = 8'($urandom);
         tick();
         k++;
      end
      check({tag, "/latency"}, k, 8);
      check({tag, "/result"}, result8, r);
      check({tag, "/flags"}, {zero8, cout8, overflow8}, {(r == 8'd0), 1'b0, (op[1] && b == 0)});
      out_ready8 = 1'b1;
      tick();
      out_ready8 = 1'b0;
   endtask

   initial begin
      rst        = 1'b1;
      in_valid   = 1'b0; out_ready  = 1'b0; src1   = '0; src2   = '0; ctrl  = '0;
      in_valid8  = 1'b0; out_ready8 = 1'b0; src1_8 = '0; src2_8 = '0; ctrl8 = '0;
      repeat (2) tick();
      check("reset/outputs", {in_ready, out_valid, zero, cout, overflow, result}, '0);
      check("reset/outputs8", {in_ready8, out_valid8, zero8, cout8, overflow8, result8}, '0);
      rst = 1'b0;
      check("reset/ready_before_edge", in_ready, 0);
      tick();
      check("reset/ready_after_edge", in_ready, 1);

      do_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1);
      do_op("add_carry", 4'b0010, 32'hFFFF_FFFF, 32'h1);
      do_op("sub_neg", 4'b0110, 32'd5, 32'd7);
      do_op("sub_ovf", 4'b0110, 32'h8000_0000, 32'h1);
      do_op("slt", 4'b0111, 32'hFFFF_FFFF, 32'h1);
      do_op("sltu", 4'b0011, 32'hFFFF_FFFF, 32'h1);
      do_op("sra", 4'b1101, 32'h8000_0000, 32'd4);
      do_op("srl", 4'b0101, 32'h8000_0000, 32'd4);
      do_op("sll31", 4'b0100, 32'h3, 32'hFFFF_FFFF);
      do_op("and", 4'b0000, 32'hF0F0, 32'h0FF0);
      do_op("or", 4'b0001, 32'hF0F0, 32'h0FF0);
      do_op("nor", 4'b1100, 32'hF0F0, 32'h0FF0);
      do_op("undef_e", 4'b1110, 32'h1234, 32'h5678);
      do_op("undef_f", 4'b1111, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mul_ff", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("mulhu_ff", 4'b1001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      do_op("divu", 4'b1010, 32'd100, 32'd7);
      do_op("remu", 4'b1011, 32'd100, 32'd7);
      do_op("divu_zero", 4'b1010, 32'h1234, 32'd0);
      do_op("remu_zero", 4'b1011, 32'h1234, 32'd0);

      // Backpressure: result held while a different op waits on in_valid.
      e        = ref_alu(4'b0010, 32'h1234, 32'h5678);
      in_valid = 1'b1; src1 = 32'h1234; src2 = 32'h5678; ctrl = 4'b0010;
      tick();
      src1 = 32'hA; src2 = 32'h5; ctrl = 4'b0001;
      check("bp/out_valid", out_valid, 1);
      for (int i = 0; i < 10; i++) begin
         tick();
         check("bp/hold", {out_valid, in_ready, zero, cout, overflow, result}, {2'b10, e});
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check("bp/release", {out_valid, in_ready}, 2'b01);
      tick();
      in_valid = 1'b0;
      check("bp/next_op", {out_valid, result}, {1'b1, 32'hF});
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;

      for (int i = 0; i < 40; i++) begin
         logic [3:0]  op;
         logic [31:0] a, b;
         op = 4'($urandom);
         a  = $urandom;
         b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
         do_op("random", op, a, b);
      end

      // Reset during the 15th BUSY cycle of a multiply.
      in_valid = 1'b1; src1 = $urandom; src2 = $urandom; ctrl = 4'b1000;
      tick();
      in_valid = 1'b0;
      repeat (14) tick();
      rst = 1'b1;
      #1;
      check("midrst/outputs", {in_ready, out_valid, zero, cout, overflow, result}, '0);
      tick();
      rst = 1'b0;
      check("midrst/ready_before_edge", in_ready, 0);
      tick();
      check("midrst/ready_after_edge", {in_ready, out_valid}, 2'b10);
      do_op("and_after_rst", 4'b0000, 32'hF0F0, 32'h0FF0);

      do_op8("w8_mul", 4'b1000, 8'hFF, 8'hFF);
      do_op8("w8_mulhu", 4'b1001, 8'hFF, 8'hFF);
      do_op8("w8_divu", 4'b1010, 8'd200, 8'd9);
      do_op8("w8_remu_zero", 4'b1011, 8'h5A, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the team's single-cycle 32-bit ALU.
- Keeps the existing logic/arithmetic op encodings and zero/cout/overflow flags.
- Adds a generic datapath width, unsigned shifts/compares, and iterative multi-cycle unsigned multiply/divide.
- Sits between the decode/issue stage and writeback; uses valid/ready on both sides so multi-cycle ops stall issue cleanly.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥4 and a power of two.
- SHW, log2(WIDTH), shift-amount bits; derived localparam, not overridable.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous active-high reset.
- in_valid  input  1  operands and opcode valid.
- in_ready  output  1  block can accept a new op.
- src1  input  WIDTH  source 1.
- src2  input  WIDTH  source 2.
- ALU_control  input  4  opcode.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  result.
- zero  output  1  result == 0.
- cout  output  1  carry out (add/sub only).
- overflow  output  1  signed overflow, or divide-by-zero.

Behaviour:
- Clocking/reset: one clock, clk. rst is asynchronous, active-high.
- While rst is high: state IDLE, in_ready=0, out_valid=0, result=0, zero=0, cout=0, overflow=0, and the iteration counter and internal accumulators are cleared.
- Reset asserted mid-operation aborts the op with no output. in_ready=1 from the first clock edge after rst deasserts.
- Opcodes:
  - 0000 AND; 0001 OR; 1100 NOR.
  - 0010 ADD: WIDTH+1-bit sum. cout = bit WIDTH. overflow = operands same sign and result sign differs.
  - 0110 SUB: computed as src1 + ~src2 + 1. cout = carry out, i.e. 1 iff src1 ≥ src2 unsigned. overflow = operands differ in sign and result sign ≠ src1 sign.
  - 0111 SLT signed; 0011 SLTU unsigned. Result 1 or 0, zero-extended.
  - 0100 SLL, 0101 SRL (logical), 1101 SRA. Shift amount = src2[SHW-1:0].
  - 1000 MUL (low WIDTH of unsigned product); 1001 MULHU (high WIDTH).
  - 1010 DIVU (quotient); 1011 REMU (remainder).
  - Undefined codes 1110, 1111: result 0, all flags 0 except zero=1.
- cout and overflow are 0 for every op except ADD/SUB, and except overflow on divide-by-zero.
- State machine:
  - IDLE: in_ready=1. Acceptance when in_valid & in_ready.
  - Single-cycle op accepted → result and flags registered on that edge → DONE.
  - MUL/MULHU/DIVU/REMU accepted → latch operands, clear counter → BUSY.
  - BUSY: in_ready=0. One radix-2 step per cycle (shift-add multiply; restoring divide). After exactly WIDTH steps, result and flags are registered → DONE.
  - DONE: out_valid=1, in_ready=0. result and flags are held stable until out_ready=1 is sampled, then → IDLE.
  - A new op cannot be accepted in the same cycle as result handoff. Peak throughput is 1 op per 2 cycles.
- Latency from the accepting edge to out_valid high:
  - Single-cycle ops: 0 edges (out_valid is high after the accept edge).
  - Multi-cycle ops: WIDTH further edges.
- Divide by zero: no special timing (still WIDTH steps). DIVU returns all ones, REMU returns src1, overflow=1, cout=0.
- zero is computed from the final registered result for every op, including undefined codes.
- src1, src2 and ALU_control are ignored outside the accept cycle. Operands changing during BUSY must not affect the result.
- in_valid held high in DONE or BUSY has no effect. The op is accepted only on return to IDLE.
- out_ready held high during IDLE/BUSY has no effect.

Test Plan (WIDTH=32 unless noted):
- Reset, then ADD with src1=0x7FFFFFFF, src2=1 → out_valid 1 cycle after accept; result=0x80000000, overflow=1, cout=0, zero=0. ADD with 0xFFFFFFFF+1 → result 0, cout=1, zero=1, overflow=0.
- SUB 5−7 → result 0xFFFFFFFE, cout=0. SLT(−1,1) → 1. SLTU(0xFFFFFFFF,1) → 0. SRA(0x80000000,4) → 0xF8000000. SLL shift amount taken from src2[4:0]=31.
- MUL 0xFFFFFFFF×0xFFFFFFFF → out_valid exactly 32 edges after accept. MUL → 0x00000001; MULHU → 0xFFFFFFFE. Operands are toggled randomly during BUSY with no effect on the result.
- DIVU 100/7 → 14; REMU → 2. DIVU x/0 with src1=0x1234 → 0xFFFFFFFF, overflow=1; REMU x/0 → 0x1234, overflow=1.
- Backpressure: hold out_ready=0 for 10 cycles in DONE → result and flags stable, in_ready=0, in_valid ignored. Release out_ready → IDLE next cycle, then the next op is accepted.
- Assert rst during the 15th BUSY cycle → all outputs 0 immediately. After release, AND 0xF0F0&0x0FF0=0x00F0 completes correctly. Repeat with WIDTH=8: MUL 0xFF×0xFF → low 0x01, completes in 8 cycles.
